// File: rtl/stall_ctrl_if.sv
// Stall controller request/response bundle.
// Requesters drive the master side, the controller the slave side.
interface stall_ctrl_if;
    logic       bbl_req;
    logic       div_start;
    logic       div_done;
    logic       mem_wait;
    logic       flush_req;
    logic [5:0] stall;
    logic       nop_insert;
    logic       flush;
    logic       div_timeout;
    logic       busy;

    modport master (
        output bbl_req, div_start, div_done, mem_wait, flush_req,
        input  stall, nop_insert, flush, div_timeout, busy
    );

    modport slave (
        input  bbl_req, div_start, div_done, mem_wait, flush_req,
        output stall, nop_insert, flush, div_timeout, busy
    );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller for the five-stage core.
// Owns multi-cycle bubble and divider holds so requesters only pulse.
module stall_ctrl #(
    parameter int BBL_CYCLES  = 2,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    stall_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN = 2'd0,
        BBL = 2'd1,
        DIV = 2'd2
    } state_t;

    localparam logic [3:0] BBL_INIT = 4'(BBL_CYCLES - 1);
    localparam logic [7:0] DIV_LIM  = 8'(DIV_TIMEOUT);

    localparam logic [5:0] HOLD_MEM = 6'b011111;
    localparam logic [5:0] HOLD_DIV = 6'b001111;
    localparam logic [5:0] HOLD_BBL = 6'b000111;

    state_t     state_q, state_d;
    logic [3:0] bbl_cnt_q, bbl_cnt_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic       pend_q, pend_d;
    logic       div_to_q, div_to_d;

    logic [5:0] stall_c;
    logic       nop_c;
    logic       flush_c;

    // State, counters, pending flush and the registered timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            bbl_cnt_q <= '0;
            div_cnt_q <= '0;
            pend_q    <= 1'b0;
            div_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bbl_cnt_q <= bbl_cnt_d;
            div_cnt_q <= div_cnt_d;
            pend_q    <= pend_d;
            div_to_q  <= div_to_d;
        end
    end

    // Priority: mem_wait, flush, divider, bubble, idle.
    always_comb begin
        state_d   = state_q;
        bbl_cnt_d = bbl_cnt_q;
        div_cnt_d = div_cnt_q;
        pend_d    = pend_q;
        div_to_d  = 1'b0;
        stall_c   = '0;
        nop_c     = 1'b0;
        flush_c   = 1'b0;

        if (bus.mem_wait) begin
            stall_c = HOLD_MEM;
            nop_c   = 1'b1;
            if (bus.flush_req) begin
                pend_d = 1'b1;
            end
        end else if (bus.flush_req || pend_q) begin
            flush_c   = 1'b1;
            state_d   = RUN;
            bbl_cnt_d = '0;
            div_cnt_d = '0;
            pend_d    = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.div_start) begin
                        stall_c   = HOLD_DIV;
                        nop_c     = 1'b1;
                        state_d   = DIV;
                        div_cnt_d = 8'd1;
                    end else if (bus.bbl_req) begin
                        stall_c = HOLD_BBL;
                        nop_c   = 1'b1;
                        if (BBL_CYCLES > 1) begin
                            state_d   = BBL;
                            bbl_cnt_d = BBL_INIT;
                        end
                    end
                end
                DIV: begin
                    if (bus.div_done) begin
                        state_d   = RUN;
                        div_cnt_d = '0;
                    end else if (div_cnt_q == DIV_LIM) begin
                        state_d   = RUN;
                        div_cnt_d = '0;
                        div_to_d  = 1'b1;
                    end else begin
                        stall_c   = HOLD_DIV;
                        nop_c     = 1'b1;
                        div_cnt_d = div_cnt_q + 8'd1;
                    end
                end
                BBL: begin
                    stall_c   = HOLD_BBL;
                    nop_c     = 1'b1;
                    bbl_cnt_d = bbl_cnt_q - 4'd1;
                    if (bbl_cnt_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Combinational holds are forced low while reset is asserted.
    assign bus.stall       = rst ? 6'b0 : stall_c;
    assign bus.nop_insert  = rst ? 1'b0 : nop_c;
    assign bus.flush       = rst ? 1'b0 : flush_c;
    assign bus.div_timeout = div_to_q;
    assign bus.busy        = (state_q != RUN) || pend_q;
endmodule

// File: tb/tb_stall_ctrl.sv
// Testbench for stall_ctrl: vector table, directed corners,
// and random traffic against a cycle-budget reference model.
module tb_stall_ctrl;
    localparam int BBL = 2;
    localparam int TO  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stall_ctrl_if bus();

    stall_ctrl #(.BBL_CYCLES(BBL), .DIV_TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: remaining bubble cycles, divider stall cycles used.
    int m_bub;
    bit m_div;
    int m_divn;
    bit m_pend;
    bit m_to;

    logic [5:0] obs_stall;
    logic       obs_to;

    typedef struct {
        logic       b, ds, dd, mw, fr;
        logic [5:0] st;
        logic       nop, fl, bsy;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic b, ds, dd, mw, fr);
        bus.bbl_req   = b;
        bus.div_start = ds;
        bus.div_done  = dd;
        bus.mem_wait  = mw;
        bus.flush_req = fr;
    endtask

    task automatic model_reset();
        m_bub  = 0;
        m_div  = 0;
        m_divn = 0;
        m_pend = 0;
        m_to   = 0;
    endtask

    // Predict this cycle's outputs, compare, then advance the model.
    task automatic model_cycle(input string tag);
        logic [5:0] es;
        bit en, ef, eb, nto;
        es  = 6'd0;
        en  = 0;
        ef  = 0;
        nto = 0;
        eb  = (m_bub > 0) || m_div || m_pend;
        if (bus.mem_wait) begin
            es = 6'd31;
            en = 1;
            if (bus.flush_req) m_pend = 1;
        end else if (bus.flush_req || m_pend) begin
            ef     = 1;
            m_bub  = 0;
            m_div  = 0;
            m_pend = 0;
        end else if (m_div) begin
            if (bus.div_done) begin
                m_div = 0;
            end else if (m_divn == TO) begin
                m_div = 0;
                nto   = 1;
            end else begin
                es = 6'd15;
                en = 1;
                m_divn++;
            end
        end else if (m_bub > 0) begin
            es = 6'd7;
            en = 1;
            m_bub--;
        end else if (bus.div_start) begin
            es     = 6'd15;
            en     = 1;
            m_div  = 1;
            m_divn = 1;
        end else if (bus.bbl_req) begin
            es    = 6'd7;
            en    = 1;
            m_bub = BBL - 1;
        end
        chk({tag, " stall"}, int'(bus.stall), int'(es));
        chk({tag, " nop"}, int'(bus.nop_insert), int'(en));
        chk({tag, " flush"}, int'(bus.flush), int'(ef));
        chk({tag, " busy"}, int'(bus.busy), int'(eb));
        chk({tag, " div_timeout"}, int'(bus.div_timeout), int'(m_to));
        m_to = nto;
    endtask

    task automatic step(input string tag, input logic b, ds, dd, mw, fr);
        set_in(b, ds, dd, mw, fr);
        @(negedge clk);
        obs_stall = bus.stall;
        obs_to    = bus.div_timeout;
        model_cycle(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        #1;
        chk("reset stall", int'(bus.stall), 0);
        chk("reset busy", int'(bus.busy), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[27];
    int   n_st;
    int   n_to;
    int   to_at;

    initial begin
        vt[0]  = '{0,0,0,0,0, 6'o00, 0,0,0};
        vt[1]  = '{1,0,0,0,0, 6'o07, 1,0,0};
        vt[2]  = '{0,0,0,0,0, 6'o07, 1,0,1};
        vt[3]  = '{0,0,0,0,0, 6'o00, 0,0,0};
        vt[4]  = '{0,0,0,0,1, 6'o00, 0,1,0};
        vt[5]  = '{0,0,0,1,0, 6'o37, 1,0,0};
        vt[6]  = '{0,0,0,1,1, 6'o37, 1,0,0};
        vt[7]  = '{0,0,0,0,0, 6'o00, 0,1,1};
        vt[8]  = '{0,0,0,0,0, 6'o00, 0,0,0};
        vt[9]  = '{1,1,0,0,0, 6'o17, 1,0,0};
        vt[10] = '{0,0,0,0,0, 6'o17, 1,0,1};
        vt[11] = '{0,0,1,0,0, 6'o00, 0,0,1};
        vt[12] = '{0,0,0,0,0, 6'o00, 0,0,0};
        vt[13] = '{1,0,0,1,0, 6'o37, 1,0,0};
        vt[14] = '{0,0,0,0,0, 6'o00, 0,0,0};
        vt[15] = '{1,0,0,0,0, 6'o07, 1,0,0};
        vt[16] = '{0,0,0,1,0, 6'o37, 1,0,1};
        vt[17] = '{0,0,0,1,1, 6'o37, 1,0,1};
        vt[18] = '{0,0,0,1,0, 6'o37, 1,0,1};
        vt[19] = '{0,0,0,0,0, 6'o00, 0,1,1};
        vt[20] = '{0,0,0,0,0, 6'o00, 0,0,0};
        vt[21] = '{0,1,0,0,1, 6'o00, 0,1,0};
        vt[22] = '{0,0,0,0,0, 6'o00, 0,0,0};
        vt[23] = '{1,0,0,0,0, 6'o07, 1,0,0};
        vt[24] = '{0,0,0,1,0, 6'o37, 1,0,1};
        vt[25] = '{0,0,0,0,0, 6'o07, 1,0,1};
        vt[26] = '{0,0,0,0,0, 6'o00, 0,0,0};

        set_in(0, 0, 0, 0, 0);
        model_reset();
        #1;
        chk("por stall", int'(bus.stall), 0);
        chk("por nop", int'(bus.nop_insert), 0);
        chk("por flush", int'(bus.flush), 0);
        chk("por busy", int'(bus.busy), 0);
        chk("por div_timeout", int'(bus.div_timeout), 0);
        do_reset();

        for (int i = 0; i < 27; i++) begin
            set_in(vt[i].b, vt[i].ds, vt[i].dd, vt[i].mw, vt[i].fr);
            @(negedge clk);
            chk($sformatf("vec%0d stall", i), int'(bus.stall), int'(vt[i].st));
            chk($sformatf("vec%0d nop", i), int'(bus.nop_insert), int'(vt[i].nop));
            chk($sformatf("vec%0d flush", i), int'(bus.flush), int'(vt[i].fl));
            chk($sformatf("vec%0d busy", i), int'(bus.busy), int'(vt[i].bsy));
            model_cycle($sformatf("vecm%0d", i));
            @(posedge clk);
            #1;
        end

        n_st = 0;
        step("bbl", 1, 0, 0, 0, 0);
        if (obs_stall == 6'o07) n_st++;
        for (int i = 0; i < 4; i++) begin
            step("bbl", 0, 0, 0, 0, 0);
            if (obs_stall == 6'o07) n_st++;
        end
        chk("bubble length", n_st, BBL);

        do_reset();
        for (int i = 0; i < 9; i++) step("div_pre", 0, 0, 0, 0, 0);
        n_st = 0;
        n_to = 0;
        step("div", 0, 1, 0, 0, 0);
        if (obs_stall == 6'o17) n_st++;
        for (int i = 0; i < 6; i++) begin
            step("div", 0, 0, 0, 0, 0);
            if (obs_stall == 6'o17) n_st++;
        end
        step("div_done", 0, 0, 1, 0, 0);
        chk("div release stall", int'(obs_stall), 0);
        for (int i = 0; i < 3; i++) begin
            step("div_post", 0, 0, 0, 0, 0);
            if (obs_to) n_to++;
        end
        chk("div stall cycles", n_st, 7);
        chk("div no timeout", n_to, 0);

        n_st  = 0;
        n_to  = 0;
        to_at = -1;
        step("tmo", 0, 1, 0, 0, 0);
        if (obs_stall != 0) n_st++;
        for (int i = 0; i < 70; i++) begin
            step("tmo", 0, 0, 0, 0, 0);
            if (obs_stall != 0) n_st++;
            if (obs_to) begin
                n_to++;
                to_at = i;
            end
        end
        chk("timeout stall cycles", n_st, TO);
        chk("timeout pulses", n_to, 1);
        chk("timeout pulse cycle", to_at, TO);
        chk("timeout idle busy", int'(bus.busy), 0);

        step("rdiv", 0, 1, 0, 0, 0);
        step("rdiv", 0, 0, 0, 0, 0);
        step("rdiv", 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst stall", int'(bus.stall), 0);
        chk("rst nop", int'(bus.nop_insert), 0);
        chk("rst flush", int'(bus.flush), 0);
        chk("rst busy", int'(bus.busy), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step("post_rst", 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 logic'($urandom_range(99) < 25),
                 logic'($urandom_range(99) < 10),
                 logic'($urandom_range(99) < 6),
                 logic'($urandom_range(99) < 15),
                 logic'($urandom_range(99) < 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
